seq_shifter: RTL and testbench

Parametrised multi-cycle shift/rotate unit for the ALU, succeeding the single-mode combinational LSR. Supports LSL, LSR, ASR and ROR on a WIDTH-bit operand and shifts up to STEP bit positions per clock. It uses a start/ready/done handshake and an optional update of the [N, Z, C, V] status flags. It sits beside the ADD/LSR units and is selected by the ALU control for shift-class instructions.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/seq_shifter_shift_step.sv | 54 +++++
 rtl/seq_shifter.sv | 140 ++++++++++++++
 tb/tb_seq_shifter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift mode encodings, status flag bit positions
// and the shifter FSM states.
package alu_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One iteration of the shifter: moves value by k (0..STEP) positions in the
// selected mode and reports the last bit shifted out (0 when k is 0).
module shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] shifted,
  output logic             carry
);

  logic        [WIDTH:0]   lsl_ext;
  logic        [WIDTH:0]   lsr_ext;
  logic signed [WIDTH:0]   asr_ext;
  logic        [WIDTH-1:0] rot;

  // An extra guard bit on each side captures the shifted-out bit for free.
  always_comb begin
    lsl_ext = {1'b0, value} << k;
    lsr_ext = {value, 1'b0} >> k;
    asr_ext = $signed({value, 1'b0}) >>> k;
    rot     = WIDTH'({value, value} >> k);
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    shifted = '0;
    carry   = 1'b0;
    case (mode)
      SH_LSL: begin
        shifted = lsl_ext[WIDTH-1:0];
        carry   = lsl_ext[WIDTH];
      end
      SH_LSR: begin
        shifted = lsr_ext[WIDTH:1];
        carry   = lsr_ext[0];
      end
      SH_ASR: begin
        shifted = asr_ext[WIDTH:1];
        carry   = asr_ext[0];
      end
      default: begin
        shifted = rot;
        carry   = lsr_ext[0];
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROR unit with start/ready/done handshake and
// optional NZCV update; shifts at most STEP positions per clock.
module seq_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  input  logic               set_flags,
  input  logic [3:0]         flags_in,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         flags_out,
  output logic               done
);

  localparam int KW = $clog2(STEP + 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic [1:0]           mode_q, mode_d;
  logic                 sf_q, sf_d;
  logic [3:0]           fin_q, fin_d;
  logic                 carry_q, carry_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q, flags_d;

  logic [KW-1:0]        k;
  logic                 rem_last;
  logic [WIDTH-1:0]     step_val;
  logic                 step_carry;

  always_comb begin
    if (32'(rem_q) >= STEP) k = KW'(STEP);
    else                    k = KW'(rem_q);
    rem_last = (32'(rem_q) <= STEP);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .value   (work_q),
    .k       (k),
    .mode    (mode_q),
    .shifted (step_val),
    .carry   (step_carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (shamt == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (rem_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
    done  = (state_q == ST_DONE);
  end

  always_comb begin
    work_d   = work_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    sf_d     = sf_q;
    fin_d    = fin_q;
    carry_d  = carry_q;
    result_d = result_q;
    flags_d  = flags_q;

    if (state_q == ST_IDLE && start) begin
      work_d  = op_a;
      rem_d   = shamt;
      mode_d  = mode;
      sf_d    = set_flags;
      fin_d   = flags_in;
      carry_d = flags_in[FLAG_C];
    end else if (state_q == ST_RUN) begin
      work_d  = step_val;
      rem_d   = rem_q - SHAMT_W'(k);
      carry_d = step_carry;
    end

    // Outputs load on the edge entering DONE so they are valid with done.
    if (state_d == ST_DONE) begin
      result_d = work_d;
      flags_d  = sf_d ? pack_flags(work_d[WIDTH-1], work_d == '0, carry_d,
                                   fin_d[FLAG_V])
                      : fin_d;
    end
  end

  // NOTE: the whole datapath is reset, not just the visible outputs, so a
  // reset mid-operation leaves no stale operand behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q   <= '0;
      rem_q    <= '0;
      mode_q   <= SH_LSL;
      sf_q     <= 1'b0;
      fin_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      work_q   <= work_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      sf_q     <= sf_d;
      fin_q    <= fin_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result    = result_q;
  assign flags_out = flags_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: a STEP=1 and a STEP=4 instance are
// compared against an arithmetic model of the shift/rotate rules.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4;
  logic [31:0] op_a;
  logic [5:0]  shamt;
  logic [1:0]  mode;
  logic        set_flags;
  logic [3:0]  flags_in;

  logic        ready1, done1, ready4, done4;
  logic [31:0] result1, result4;
  logic [3:0]  flags1, flags4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .ready     (ready1),
    .op_a      (op_a),
    .shamt     (shamt[4:0]),
    .mode      (mode),
    .set_flags (set_flags),
    .flags_in  (flags_in),
    .result    (result1),
    .flags_out (flags1),
    .done      (done1)
  );

  seq_shifter #(.WIDTH(32), .SHAMT_W(6), .STEP(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .ready     (ready4),
    .op_a      (op_a),
    .shamt     (shamt),
    .mode      (mode),
    .set_flags (set_flags),
    .flags_in  (flags_in),
    .result    (result4),
    .flags_out (flags4),
    .done      (done4)
  );

  // Reference model: whole-operation semantics computed in one go.
  function automatic void model(input logic [31:0] a, input int s,
                                input logic [1:0] m, input logic sf,
                                input logic [3:0] fin,
                                output logic [31:0] r, output logic [3:0] f);
    logic c;
    int   rr;
    if (s == 0) begin
      r = a;
      c = fin[1];
    end else begin
      case (m)
        2'b00: begin
          r = (s >= 32) ? 32'd0 : a << s;
          c = (s <= 32) ? a[32-s] : 1'b0;
        end
        2'b01: begin
          r = (s >= 32) ? 32'd0 : a >> s;
          c = (s <= 32) ? a[s-1] : 1'b0;
        end
        2'b10: begin
          r = (s >= 32) ? {32{a[31]}} : 32'($signed(a) >>> s);
          c = (s <= 32) ? a[s-1] : a[31];
        end
        default: begin
          rr = s % 32;
          r  = (rr == 0) ? a : ((a >> rr) | (a << (32 - rr)));
          c  = r[31];
        end
      endcase
    end
    f = sf ? {r[31], (r == 32'd0), c, fin[0]} : fin;
  endfunction

  // Runs one operation on the selected instance; returns observed outputs
  // and the number of edges after the accept edge until done was seen.
  task automatic do_op(input bit use4, input logic [31:0] a,
                       input logic [5:0] s, input logic [1:0] m,
                       input logic sf, input logic [3:0] fin,
                       output logic [31:0] r, output logic [3:0] f,
                       output int cyc);
    op_a = a; shamt = s; mode = m; set_flags = sf; flags_in = fin;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    op_a = $urandom; shamt = 6'($urandom); mode = 2'($urandom);
    set_flags = 1'($urandom); flags_in = 4'($urandom);
    cyc = 0;
    while (!(use4 ? done4 : done1) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    r = use4 ? result4 : result1;
    f = use4 ? flags4 : flags1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    op_a = '0; shamt = '0; mode = '0; set_flags = 1'b0; flags_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b want 1", ready1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1 got %b want 0", done1); end
    checks++; if (result1 !== 32'd0) begin errors++; $display("FAIL reset_result1 got %h want 0", result1); end
    checks++; if (flags1 !== 4'b0000) begin errors++; $display("FAIL reset_flags1 got %b want 0000", flags1); end
    checks++; if (ready4 !== 1'b1 || done4 !== 1'b0) begin errors++; $display("FAIL reset_hs4 got ready=%b done=%b want 1/0", ready4, done4); end
  endtask

  typedef struct packed {
    logic        use4;
    logic [31:0] a;
    logic [5:0]  s;
    logic [1:0]  m;
    logic        sf;
    logic [3:0]  fin;
    logic [31:0] exp_r;
    logic [3:0]  exp_f;
    logic [7:0]  exp_cyc;
  } vec_t;

  task automatic test_directed();
    vec_t        v[$];
    logic [31:0] r;
    logic [3:0]  f;
    int          cyc;
    v.push_back('{1'b0, 32'h0000_0003, 6'd1,  2'b01, 1'b1, 4'b0000, 32'h0000_0001, 4'b0010, 8'd1});
    v.push_back('{1'b0, 32'hFFFF_FFFA, 6'd4,  2'b10, 1'b1, 4'b0000, 32'hFFFF_FFFF, 4'b1010, 8'd4});
    v.push_back('{1'b0, 32'hFFFF_FFFA, 6'd4,  2'b10, 1'b0, 4'b0101, 32'hFFFF_FFFF, 4'b0101, 8'd4});
    v.push_back('{1'b1, 32'hFFFF_FFFF, 6'd9,  2'b01, 1'b1, 4'b0000, 32'h007F_FFFF, 4'b0010, 8'd3});
    v.push_back('{1'b0, 32'h8000_0001, 6'd1,  2'b11, 1'b1, 4'b0000, 32'hC000_0000, 4'b1010, 8'd1});
    v.push_back('{1'b0, 32'h8000_0000, 6'd1,  2'b00, 1'b1, 4'b0000, 32'h0000_0000, 4'b0110, 8'd1});
    v.push_back('{1'b0, 32'h0000_0000, 6'd0,  2'b00, 1'b1, 4'b0011, 32'h0000_0000, 4'b0111, 8'd0});
    v.push_back('{1'b1, 32'h8000_0001, 6'd32, 2'b00, 1'b1, 4'b0000, 32'h0000_0000, 4'b0110, 8'd8});
    v.push_back('{1'b1, 32'h8000_0001, 6'd33, 2'b01, 1'b1, 4'b0000, 32'h0000_0000, 4'b0100, 8'd9});
    v.push_back('{1'b1, 32'h8000_0000, 6'd40, 2'b10, 1'b1, 4'b0001, 32'hFFFF_FFFF, 4'b1011, 8'd10});
    v.push_back('{1'b1, 32'h1234_5678, 6'd36, 2'b11, 1'b1, 4'b0000, 32'h8123_4567, 4'b1010, 8'd9});
    v.push_back('{1'b0, 32'h0000_0001, 6'd31, 2'b00, 1'b1, 4'b0000, 32'h8000_0000, 4'b1000, 8'd31});
    foreach (v[i]) begin
      do_op(v[i].use4, v[i].a, v[i].s, v[i].m, v[i].sf, v[i].fin, r, f, cyc);
      checks++; if (r !== v[i].exp_r) begin errors++; $display("FAIL directed_result[%0d] got %h want %h", i, r, v[i].exp_r); end
      checks++; if (f !== v[i].exp_f) begin errors++; $display("FAIL directed_flags[%0d] got %b want %b", i, f, v[i].exp_f); end
      checks++; if (cyc != int'(v[i].exp_cyc)) begin errors++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, cyc, v[i].exp_cyc); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, r, er;
    logic [5:0]  s;
    logic [1:0]  m;
    logic        sf;
    logic [3:0]  fin, f, ef;
    int          cyc, step;
    bit          use4;
    for (int i = 0; i < 80; i++) begin
      use4 = (i >= 40);
      step = use4 ? 4 : 1;
      a    = $urandom;
      s    = use4 ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 31));
      m    = 2'($urandom);
      sf   = 1'($urandom);
      fin  = 4'($urandom);
      model(a, int'(s), m, sf, fin, er, ef);
      do_op(use4, a, s, m, sf, fin, r, f, cyc);
      checks++; if (r !== er) begin errors++; $display("FAIL rand_result[%0d] a=%h s=%0d m=%0d got %h want %h", i, a, s, m, r, er); end
      checks++; if (f !== ef) begin errors++; $display("FAIL rand_flags[%0d] a=%h s=%0d m=%0d got %b want %b", i, a, s, m, f, ef); end
      checks++; if (cyc != (int'(s) + step - 1) / step) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, cyc, (int'(s) + step - 1) / step); end
    end
  endtask

  task automatic test_start_during_run();
    logic [31:0] er;
    logic [3:0]  ef;
    int          cyc;
    bit          extra;
    model(32'h0000_00F0, 5, 2'b01, 1'b1, 4'b0000, er, ef);
    op_a = 32'h0000_00F0; shamt = 6'd5; mode = 2'b01; set_flags = 1'b1; flags_in = 4'b0000;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    op_a = 32'hDEAD_BEEF; shamt = 6'd2; mode = 2'b11; set_flags = 1'b0; flags_in = 4'b1111;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 2;
    while (!done1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc != 5) begin errors++; $display("FAIL run_start_latency got %0d want 5", cyc); end
    checks++; if (result1 !== er || flags1 !== ef) begin errors++; $display("FAIL run_start_result got %h/%b want %h/%b", result1, flags1, er, ef); end
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL done_ready got %b want 0", ready1); end
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    extra = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done1) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0 || ready1 !== 1'b1) begin errors++; $display("FAIL done_start_ignored got extra_done=%b ready=%b want 0/1", extra, ready1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    logic [3:0]  ef;
    int          cyc, period;
    model(32'hF0F0_F0F0, 8, 2'b00, 1'b1, 4'b0100, er, ef);
    op_a = 32'hF0F0_F0F0; shamt = 6'd8; mode = 2'b00; set_flags = 1'b1; flags_in = 4'b0100;
    start4 = 1'b1;
    cyc = 0;
    while (!done4 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    period = 0;
    do begin
      @(posedge clk); #1;
      period++;
    end while (!done4 && period < 50);
    start4 = 1'b0;
    checks++; if (period != 4) begin errors++; $display("FAIL b2b_period got %0d want 4", period); end
    checks++; if (result4 !== er || flags4 !== ef) begin errors++; $display("FAIL b2b_result got %h/%b want %h/%b", result4, flags4, er, ef); end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_run_reset();
    logic [31:0] r;
    logic [3:0]  f;
    int          cyc;
    bit          extra;
    do_op(1'b0, 32'h0000_0005, 6'd1, 2'b00, 1'b1, 4'b0000, r, f, cyc);
    checks++; if (result1 !== 32'h0000_000A) begin errors++; $display("FAIL pre_reset_result got %h want 0000000a", result1); end
    op_a = 32'h0000_FFFF; shamt = 6'd20; mode = 2'b00; set_flags = 1'b1; flags_in = 4'b1111;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ready1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL abort_hs got ready=%b done=%b want 1/0", ready1, done1); end
    checks++; if (result1 !== 32'd0 || flags1 !== 4'b0000) begin errors++; $display("FAIL abort_outputs got %h/%b want 0/0000", result1, flags1); end
    extra = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done1) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL abort_no_done got done seen=%b want 0", extra); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_mid_run_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
